multicycle_control: RTL

//  Multi-cycle main-control FSM for the LEGv8 ARM core. Sequences fetch/decode/execute/memory/writeback
//  for ADD, SUB, AND, ORR, ADDI, LDUR, STUR, CBZ and B.

---
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main-control FSM for the multi-cycle LEGv8 core: sequences fetch, decode, execute, memory and
// writeback, and decodes every datapath strobe from the current state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        alu_op1,
  output logic        alu_op0,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        ir_valid,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg2loc,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        busy,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, R_WB, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH_CB, JUMP, ERROR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic            is_store;
  logic            timed_out;
  logic            unused_fields;

  // Register fields are consumed by the datapath; only the opcode matters here.
  assign unused_fields = ^instr[20:0];

  // Last permitted wait cycle with no handshake; a same-cycle mem_ready still wins.
  assign timed_out = !mem_ready && (to_cnt == TO_LAST);

  function automatic state_t decode_op(input logic [10:0] op);
    state_t nxt;
    nxt = ERROR;
    if (op inside {11'h458, 11'h658, 11'h450, 11'h550}) nxt = EXEC_R;
    else if (op[10:1] == 10'h244)                       nxt = EXEC_I;
    else if (op == 11'h7C2 || op == 11'h7C0)            nxt = MEM_ADDR;
    else if (op[10:3] == 8'hB4)                         nxt = BRANCH_CB;
    else if (op[10:5] == 6'b000101)                     nxt = JUMP;
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      to_cnt   <= '0;
      is_store <= 1'b0;
    end else begin
      case (state)
        IDLE: if (run) begin
          state  <= FETCH;
          to_cnt <= '0;
        end
        FETCH: begin
          if (mem_ready)      state  <= DECODE;
          else if (timed_out) state  <= ERROR;
          else                to_cnt <= to_cnt + TO_W'(1);
        end
        DECODE: begin
          state    <= decode_op(instr[31:21]);
          is_store <= (instr[31:21] == 11'h7C0);
        end
        EXEC_R, EXEC_I: state <= R_WB;
        MEM_ADDR: begin
          state  <= is_store ? MEM_WR : MEM_RD;
          to_cnt <= '0;
        end
        MEM_RD: begin
          if (mem_ready)      state  <= MEM_WB;
          else if (timed_out) state  <= ERROR;
          else                to_cnt <= to_cnt + TO_W'(1);
        end
        MEM_WR: begin
          if (mem_ready) begin
            state  <= run ? FETCH : IDLE;
            to_cnt <= '0;
          end else if (timed_out) begin
            state  <= ERROR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        R_WB, MEM_WB, BRANCH_CB, JUMP: begin
          state  <= run ? FETCH : IDLE;
          to_cnt <= '0;
        end
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_op1    = 1'b0;
    alu_op0    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    ir_valid   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg2loc    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    busy       = (state != IDLE) && (state != ERROR);
    err        = (state == ERROR);
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        ir_valid  = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op1   = 1'b1;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      R_WB: reg_write = 1'b1;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        reg2loc   = is_store;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        reg2loc   = 1'b1;
      end
      BRANCH_CB: begin
        reg2loc   = 1'b1;
        alu_src_a = 1'b1;
        alu_op0   = 1'b1;
        pc_src    = 2'd1;
        pc_write  = alu_zero;
      end
      JUMP: begin
        pc_src   = 2'd2;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
